uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the 8N1 UART link: 8 data bits, LSB first, one start bit, one stop bit, no parity. It oversamples the asynchronous RX pin with the system clock and samples each bit at its centre. Each received byte is presented on a parallel bus with a one-cycle valid strobe, and stop-bit errors are flagged. It sits at the pin boundary opposite the team's UART transmitter and uses the same CLKS_PER_BIT convention (clock frequency / baud rate, e.g. 25 MHz / 115200 = 217).

## Interface
- CLKS_PER_BIT, 217, system clocks per UART bit; legal range 4..65535.
- CLK  input  1  system clock; all logic on rising edge.
- i_Rst  input  1  asynchronous, active-high reset.
- i_RX  input  1  raw serial line; idle high; asynchronous to CLK.
- o_RX_DV  output  1  one-cycle strobe: o_RX_Byte holds a valid, correctly framed byte.
- o_RX_Byte  output  8  last received byte; holds its value until the next byte completes.
- o_RX_Frame_Err  output  1  one-cycle strobe: stop bit was sampled low.
- o_RX_Active  output  1  high while a frame is being received (START through STOP).

## Operation
- One clock; reset is asynchronous and active-high.
- Synchronizer: 2-flop chain on i_RX, output r_RX. Both flops reset to 1. All decisions use r_RX only.
- H = (CLKS_PER_BIT-1)/2, using integer division.
- Clock counter width is $clog2(CLKS_PER_BIT). The counter never exceeds CLKS_PER_BIT-1.
- States:
  - IDLE: count=0, bit index=0. When r_RX==0, go to START.
  - START: when count==H, re-check r_RX.
    - r_RX==0: go to DATA, count=0, set o_RX_Active.
    - r_RX==1: glitch; return to IDLE with no strobe.
    - Otherwise count++.
  - DATA: when count==CLKS_PER_BIT-1, shift r_RX into bit[index] and set count=0.
    - index<7: index++.
    - index==7: index=0, go to STOP.
    - Otherwise count++.
  - STOP: when count==CLKS_PER_BIT-1, sample r_RX and clear o_RX_Active.
    - 1: load o_RX_Byte from the shift register, pulse o_RX_DV, go to CLEANUP.
    - 0: load o_RX_Byte anyway, pulse o_RX_Frame_Err, go to BREAK_WAIT.
  - CLEANUP: one cycle, strobes low, go to IDLE.
  - BREAK_WAIT: stay while r_RX==0. Go to IDLE on the first cycle r_RX==1. A held-low line (break) therefore never retriggers START.
  - Illegal or undefined encodings go to IDLE.
- o_RX_DV and o_RX_Frame_Err are never high in the same cycle.
- Reset asserted at any time, including mid-frame:
  - State goes to IDLE immediately.
  - All outputs go to 0 and o_RX_Byte to 8'h00.
  - The partial byte is discarded and no strobe is issued.
- Reset values: o_RX_DV=0, o_RX_Byte=8'h00, o_RX_Frame_Err=0, o_RX_Active=0, sync flops=1.

## Timing
- p0 is the first CLK edge at which the first sync flop captures a low i_RX. IDLE sees r_RX==0 at edge p2.
- Start check occurs at edge p2+H+1.
- Data bit i (0..7) is sampled at edge p2+H+1+(i+1)*CLKS_PER_BIT.
- Stop bit is sampled at edge p2+H+1+9*CLKS_PER_BIT. o_RX_DV or o_RX_Frame_Err is high for exactly the following cycle.
- Pin fall to strobe: H+3+9*CLKS_PER_BIT edges. With CLKS_PER_BIT=217 this is 2064; with CLKS_PER_BIT=8 it is 78.
- o_RX_Active:
  - Rises after edge p2+H+1.
  - Falls in the same cycle the strobe rises.
- Back-to-back frames: a start bit that begins immediately after a valid stop bit is detected.
  - The CLEANUP cycle plus sampling the stop bit at its centre leaves at least H-1 cycles of margin.
- Minimum glitch rejected: any low pulse on r_RX shorter than H+1 cycles.

## Test plan
All scenarios use CLKS_PER_BIT=8 unless stated.

- Reset: hold i_Rst=1 for 3 cycles with i_RX toggling.
  - Required: all outputs 0 and o_RX_Byte=8'h00 throughout.
  - Required: no strobe within 100 cycles after release with i_RX=1.
- Single byte 8'hA5, ideal bit timing.
  - Required: o_RX_DV high for exactly 1 cycle, 78 edges after p0.
  - Required: o_RX_Byte=8'hA5, o_RX_Frame_Err stays 0.
- Back-to-back 8'h00 then 8'hFF, each stop bit exactly 8 cycles.
  - Required: two o_RX_DV pulses 80 cycles apart, bytes 8'h00 then 8'hFF.
- Glitch: i_RX low for 2 cycles, then high.
  - Required: o_RX_Active never rises, no strobe.
  - Then a valid 8'h3C: received correctly.
- Framing error/break: send 8'h55 with the stop bit low, then hold the line low for 200 cycles.
  - Required: o_RX_Frame_Err pulses once, o_RX_DV stays 0, o_RX_Byte=8'h55.
  - Required: no further strobes while low.
  - After the line returns high, 8'h81 is received correctly.
- Mid-frame reset: assert i_Rst for 1 cycle during data bit 4 of 8'hC3.
  - Required: o_RX_Active drops at once, no strobe for that frame.
  - Next frame 8'h7E is received correctly.
- Also run the single-byte scenario with CLKS_PER_BIT=217.
  - Required: o_RX_DV at edge 2064.
  - Required: ±2% baud skew on the sender is still received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (8 data bits LSB first, 1 start, 1 stop, no parity).
// The RX pin goes through a two-flop synchronizer. A start edge is confirmed at
// mid-bit, and every data and stop bit is then sampled at its centre.
//
// Ports
//   CLK            system clock, rising edge
//   i_Rst          asynchronous active-high reset
//   i_RX           raw serial line, idle high, asynchronous to CLK
//   o_RX_DV        one-cycle strobe: o_RX_Byte holds a correctly framed byte
//   o_RX_Byte      last received byte, held until the next frame completes
//   o_RX_Frame_Err one-cycle strobe: stop bit sampled low
//   o_RX_Active    high from the confirmed start bit through the stop sample
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       CLK,
  input  logic       i_Rst,
  input  logic       i_RX,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Frame_Err,
  output logic       o_RX_Active
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_CLEANUP,
    S_BREAK_WAIT
  } state_e;

  logic             rx_meta_q;
  logic             rx_sync_q;
  state_e           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [2:0]       idx_q,    idx_d;
  logic [7:0]       shift_q,  shift_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             dv_q,     dv_d;
  logic             ferr_q,   ferr_d;
  logic             active_q, active_d;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge CLK or posedge i_Rst) begin
    if (i_Rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_RX;
      rx_sync_q <= rx_meta_q;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge i_Rst) begin
    if (i_Rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      rx_byte_q <= '0;
      dv_q      <= 1'b0;
      ferr_q    <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      rx_byte_q <= rx_byte_d;
      dv_q      <= dv_d;
      ferr_q    <= ferr_d;
      active_q  <= active_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    rx_byte_d = rx_byte_q;
    dv_d      = 1'b0;
    ferr_d    = 1'b0;
    active_d  = active_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_sync_q) state_d = S_START;
      end

      // Re-check the line at mid start bit so that short glitches are dropped.
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_sync_q) begin
            state_d  = S_DATA;
            active_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_sync_q;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // The byte is loaded even on a bad stop bit so that it can be inspected.
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          active_d  = 1'b0;
          rx_byte_d = shift_q;
          if (rx_sync_q) begin
            dv_d    = 1'b1;
            state_d = S_CLEANUP;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK_WAIT;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_CLEANUP: state_d = S_IDLE;

      // A held-low line (break) must not be taken as a new start bit.
      S_BREAK_WAIT: begin
        if (rx_sync_q) state_d = S_IDLE;
      end

      default: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
      end
    endcase
  end

  assign o_RX_DV        = dv_q;
  assign o_RX_Byte      = rx_byte_q;
  assign o_RX_Frame_Err = ferr_q;
  assign o_RX_Active    = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. One instance runs at 8 clocks per bit
// and a second at 217. Both share the clock and the reset. A negedge monitor
// counts strobes and records when they occur.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx8 = 1'b1;
  logic       rx217 = 1'b1;
  logic       dv8, fe8, act8;
  logic [7:0] byte8;
  logic       dv217, fe217, act217;
  logic [7:0] byte217;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  int t_fall = 0;

  int dv_cnt8 = 0, fe_cnt8 = 0, rise8 = 0, long8 = 0, both8 = 0, dv_edge8 = 0;
  int dv_cnt217 = 0, fe_cnt217 = 0, both217 = 0, dv_edge217 = 0;
  logic [7:0] dv_byte8 = 8'h00, dv_byte217 = 8'h00;
  logic dv8_prev = 1'b0, act8_prev = 1'b0;

  uart_rx #(.CLKS_PER_BIT(8)) dut8 (
    .CLK(clk), .i_Rst(rst), .i_RX(rx8),
    .o_RX_DV(dv8), .o_RX_Byte(byte8), .o_RX_Frame_Err(fe8), .o_RX_Active(act8)
  );

  uart_rx #(.CLKS_PER_BIT(217)) dut217 (
    .CLK(clk), .i_Rst(rst), .i_RX(rx217),
    .o_RX_DV(dv217), .o_RX_Byte(byte217), .o_RX_Frame_Err(fe217), .o_RX_Active(act217)
  );

  always #5 clk = ~clk;

  // cyc equals the index of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (dv8) begin
      dv_cnt8  <= dv_cnt8 + 1;
      dv_edge8 <= cyc;
      dv_byte8 <= byte8;
    end
    if (dv8 && dv8_prev) long8 <= long8 + 1;
    if (fe8) fe_cnt8 <= fe_cnt8 + 1;
    if (dv8 && fe8) both8 <= both8 + 1;
    if (act8 && !act8_prev) rise8 <= rise8 + 1;
    dv8_prev  <= dv8;
    act8_prev <= act8;
    if (dv217) begin
      dv_cnt217  <= dv_cnt217 + 1;
      dv_edge217 <= cyc;
      dv_byte217 <= byte217;
    end
    if (fe217) fe_cnt217 <= fe_cnt217 + 1;
    if (dv217 && fe217) both217 <= both217 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame. len100 is the bit length in hundredths of a clock, which
  // allows baud skew. rst_cyc >= 0 pulses reset for one cycle at that cycle.
  task automatic send(input bit big, input logic [7:0] b, input bit stop_bit,
                      input int len100, input int rst_cyc);
    logic [9:0] frame;
    int total, slot;
    frame  = {stop_bit, b, 1'b0};
    total  = (10 * len100) / 100;
    t_fall = cyc;
    for (int c = 0; c < total; c++) begin
      slot = (c * 100) / len100;
      if (big) rx217 = frame[4'(slot)];
      else     rx8   = frame[4'(slot)];
      if (c == rst_cyc) begin
        chk("mid_active_before", 32'(act8), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_active_dropped", 32'(act8), 32'h0);
      end else begin
        rst = 1'b0;
      end
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  initial begin
    int b_dv, b_fe, b_rise, tf1, e1;
    logic [7:0] b1;

    // Reset held with the line toggling.
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rx8   = ~rx8;
      rx217 = ~rx217;
      #1;
      chk("reset_outputs8", 32'({dv8, fe8, act8, byte8}), 32'h0);
      chk("reset_outputs217", 32'({dv217, fe217, act217, byte217}), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0; rx8 = 1'b1; rx217 = 1'b1;
    idle(100);
    chk("post_reset_dv8", 32'(dv_cnt8), 32'h0);
    chk("post_reset_fe8", 32'(fe_cnt8), 32'h0);
    chk("post_reset_active8", 32'(rise8), 32'h0);
    chk("post_reset_dv217", 32'(dv_cnt217), 32'h0);

    // Single byte, ideal timing: strobe loads at edge p0+78, with p0 = t_fall+1.
    b_dv = dv_cnt8; b_fe = fe_cnt8;
    send(1'b0, 8'hA5, 1'b1, 800, -1);
    tf1 = t_fall;
    idle(5);
    chk("a5_count", 32'(dv_cnt8 - b_dv), 32'd1);
    chk("a5_latency", 32'(dv_edge8 - tf1), 32'd79);
    chk("a5_byte", 32'(dv_byte8), 32'hA5);
    chk("a5_byte_held", 32'(byte8), 32'hA5);
    chk("a5_no_ferr", 32'(fe_cnt8 - b_fe), 32'd0);
    chk("a5_dv_width", 32'(long8), 32'd0);

    // Back-to-back frames with no idle gap.
    b_dv = dv_cnt8;
    send(1'b0, 8'h00, 1'b1, 800, -1);
    tf1 = t_fall; e1 = dv_edge8; b1 = dv_byte8;
    send(1'b0, 8'hFF, 1'b1, 800, -1);
    idle(5);
    chk("b2b_first_latency", 32'(e1 - tf1), 32'd79);
    chk("b2b_spacing", 32'(dv_edge8 - e1), 32'd80);
    chk("b2b_byte0", 32'(b1), 32'h00);
    chk("b2b_byte1", 32'(dv_byte8), 32'hFF);
    chk("b2b_count", 32'(dv_cnt8 - b_dv), 32'd2);

    // Two-cycle glitch is rejected, then a real frame follows.
    b_dv = dv_cnt8; b_fe = fe_cnt8; b_rise = rise8;
    rx8 = 1'b0; idle(2); rx8 = 1'b1; idle(20);
    chk("glitch_active", 32'(rise8 - b_rise), 32'd0);
    chk("glitch_dv", 32'(dv_cnt8 - b_dv), 32'd0);
    chk("glitch_fe", 32'(fe_cnt8 - b_fe), 32'd0);
    send(1'b0, 8'h3C, 1'b1, 800, -1);
    idle(5);
    chk("post_glitch_byte", 32'(dv_byte8), 32'h3C);
    chk("post_glitch_count", 32'(dv_cnt8 - b_dv), 32'd1);

    // Framing error followed by a long break.
    b_dv = dv_cnt8; b_fe = fe_cnt8;
    send(1'b0, 8'h55, 1'b0, 800, -1);
    idle(200);
    chk("ferr_count", 32'(fe_cnt8 - b_fe), 32'd1);
    chk("ferr_no_dv", 32'(dv_cnt8 - b_dv), 32'd0);
    chk("ferr_byte", 32'(byte8), 32'h55);
    rx8 = 1'b1; idle(20);
    chk("break_no_retrigger", 32'(fe_cnt8 - b_fe), 32'd1);
    send(1'b0, 8'h81, 1'b1, 800, -1);
    idle(5);
    chk("post_break_byte", 32'(dv_byte8), 32'h81);
    chk("post_break_count", 32'(dv_cnt8 - b_dv), 32'd1);

    // Reset in the middle of data bit 4 (cycles 40..47 of the frame).
    b_dv = dv_cnt8; b_fe = fe_cnt8;
    send(1'b0, 8'hC3, 1'b1, 800, 44);
    idle(10);
    chk("mid_no_dv", 32'(dv_cnt8 - b_dv), 32'd0);
    chk("mid_no_fe", 32'(fe_cnt8 - b_fe), 32'd0);
    // After reset the receiver sees the frame's remaining low bits as a new
    // start bit and frames them. Let that settle before the next frame.
    idle(60);
    send(1'b0, 8'h7E, 1'b1, 800, -1);
    tf1 = t_fall;
    idle(5);
    chk("post_reset_byte", 32'(dv_byte8), 32'h7E);
    chk("post_reset_latency", 32'(dv_edge8 - tf1), 32'd79);

    // 217 clocks per bit: nominal timing, then +2% and -2% sender skew.
    b_dv = dv_cnt217;
    send(1'b1, 8'hA5, 1'b1, 21700, -1);
    tf1 = t_fall;
    idle(5);
    chk("c217_latency", 32'(dv_edge217 - tf1), 32'd2065);
    chk("c217_byte", 32'(dv_byte217), 32'hA5);
    send(1'b1, 8'h3C, 1'b1, 22134, -1);
    idle(5);
    chk("c217_slow_byte", 32'(dv_byte217), 32'h3C);
    send(1'b1, 8'hC3, 1'b1, 21266, -1);
    idle(5);
    chk("c217_fast_byte", 32'(dv_byte217), 32'hC3);
    chk("c217_count", 32'(dv_cnt217 - b_dv), 32'd3);
    chk("c217_no_ferr", 32'(fe_cnt217), 32'd0);

    chk("exclusive_strobes8", 32'(both8), 32'd0);
    chk("exclusive_strobes217", 32'(both217), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
